// File: rtl/led_pkg.sv
// Shared types for the LED breathing stage: envelope FSM state encoding.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } breath_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: tick is high in the terminal-count cycle of every
// PRESCALE_CNT-cycle window. PRESCALE_CNT of 0 behaves like 1 (tick every cycle).
module led_tick_gen
    import led_pkg::*;
#(
    parameter logic [31:0] PRESCALE_CNT = 32'd100
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] TERM  = (PRESCALE_CNT == 32'd0) ? 32'd0 : PRESCALE_CNT - 32'd1;
    localparam int          CNT_W = (TERM == 32'd0) ? 1 : $clog2(33'(TERM) + 33'd1);
    localparam logic [CNT_W-1:0] TERM_C  = CNT_W'(TERM);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERM_C);

    always_ff @(posedge sys_clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/led_breath_pwm.sv
// Breathing PWM stage: gates the incoming LED pattern with a shared PWM whose
// duty ramps 0 -> max, dwells, ramps back to 0, dwells, and repeats.
module led_breath_pwm
    import led_pkg::*;
#(
    parameter logic [31:0] PRESCALE_CNT = 32'd100,
    parameter int          PWM_BITS     = 8,
    parameter int          HOLD_PERIODS = 16,
    parameter int          NUM_LED      = 4
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_LED-1:0]  led_in,
    output logic [NUM_LED-1:0]  led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                period_tick
);

    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam int                  STEP_W   = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = (HOLD_PERIODS > 1) ? STEP_W'(HOLD_PERIODS - 1) : '0;
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);

    function automatic logic [PWM_BITS-1:0] duty_inc_sat(input logic [PWM_BITS-1:0] d);
        return (d == PWM_MAX) ? d : d + PWM_ONE;
    endfunction

    function automatic logic [PWM_BITS-1:0] duty_dec_sat(input logic [PWM_BITS-1:0] d);
        return (d == '0) ? d : d - PWM_ONE;
    endfunction

    breath_state_t       state;
    breath_state_t       state_nx;
    logic [PWM_BITS-1:0] duty_nx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                pwm_step;
    logic                step_evt;
    logic                clear;
    logic                bypass;
    logic                pwm_on;

    // Timebase is held at phase 0 whenever breathing is not running, so every
    // envelope starts from a clean period boundary.
    assign clear  = (state == IDLE) || !enable;
    assign bypass = clear;

    led_tick_gen #(
        .PRESCALE_CNT(PRESCALE_CNT)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (clear),
        .tick    (pwm_step)
    );

    assign step_evt = period_tick && (step_cnt == STEP_LAST);
    assign pwm_on   = (pwm_cnt < duty);

    always_comb begin
        state_nx = state;
        duty_nx  = duty;
        if (!enable) begin
            state_nx = IDLE;
            duty_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = RISE;
                    duty_nx  = '0;
                end
                RISE: begin
                    if (step_evt) begin
                        duty_nx = duty_inc_sat(duty);
                        if (duty_nx == PWM_MAX) state_nx = HOLD_HI;
                    end
                end
                HOLD_HI: begin
                    if (step_evt) state_nx = FALL;
                end
                FALL: begin
                    if (step_evt) begin
                        duty_nx = duty_dec_sat(duty);
                        if (duty_nx == '0) state_nx = HOLD_LO;
                    end
                end
                HOLD_LO: begin
                    if (step_evt) state_nx = RISE;
                end
                default: begin
                    state_nx = IDLE;
                    duty_nx  = '0;
                end
            endcase
        end
    end

    // Timebase: PWM counter, end-of-period pulse and duty-step counter
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pwm_cnt     <= '0;
            period_tick <= 1'b0;
            step_cnt    <= '0;
        end else begin
            if (clear) begin
                pwm_cnt <= '0;
            end else if (pwm_step) begin
                pwm_cnt <= pwm_cnt + PWM_ONE;
            end
            period_tick <= !clear && pwm_step && (pwm_cnt == PWM_MAX);
            if (clear || (state_nx != state)) begin
                step_cnt <= '0;
            end else if (period_tick) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_ONE;
            end
        end
    end

    // Envelope state and output register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state   <= IDLE;
            duty    <= '0;
            led_out <= '0;
        end else begin
            state   <= state_nx;
            duty    <= duty_nx;
            led_out <= bypass ? led_in : (led_in & {NUM_LED{pwm_on}});
        end
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Scoreboard bench for led_breath_pwm using a closed-form envelope model
// indexed by cycles since the envelope started.
module tb_led_breath_pwm;

    localparam int PRE   = 4;
    localparam int MAXD  = 15;
    localparam int PER   = PRE * (MAXD + 1);
    localparam int STEP  = PER * 2;
    localparam int ENV   = 2 * (MAXD + 1) * STEP;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] led_in;
    logic [3:0] led_out;
    logic [3:0] duty;
    logic       period_tick;

    always #5 sys_clk = ~sys_clk;

    led_breath_pwm #(
        .PRESCALE_CNT (32'd4),
        .PWM_BITS     (4),
        .HOLD_PERIODS (2),
        .NUM_LED      (4)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .enable      (enable),
        .led_in      (led_in),
        .led_out     (led_out),
        .duty        (duty),
        .period_tick (period_tick)
    );

    typedef struct {
        int         t;
        int         n;
        logic [3:0] led;
        logic [3:0] duty;
        logic       tick;
        logic       awin;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int m_t    = -1;
    int edge_n = 0;
    int rel_n  = 0;

    logic awin  = 1'b0;
    logic win5  = 1'b0;
    logic tarm  = 1'b0;
    logic rewin = 1'b0;
    int first_tick_n = -1;
    int hi5 = 0;
    int lo5 = 0;
    int a_bit0 = 0;
    int a_bit1_obs = 0;
    int a_bit1_exp = 0;
    int first_d1_t = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pwm(input int t);
        return (t / PRE) % (MAXD + 1);
    endfunction

    function automatic int model_duty(input int t);
        int s;
        int e;
        s = (t <= 0) ? 0 : (t - 1) / STEP;
        e = s % (2 * (MAXD + 1));
        return (e <= MAXD) ? e : (2 * MAXD + 1 - e);
    endfunction

    task automatic observe(input exp_t e);
        if (tarm && first_tick_n < 0 && period_tick === 1'b1) first_tick_n = e.n;
        if (win5 && e.t >= 705 && e.t <= 768) begin
            if (led_out[0] === 1'b1) hi5++;
            else lo5++;
        end
        if (e.awin) begin
            if (led_out[0] === 1'b1) a_bit0++;
            if (led_out[1] === 1'b1) a_bit1_obs++;
            if (e.led[1]) a_bit1_exp++;
        end
        if (rewin && first_d1_t < 0 && duty === 4'd1) first_d1_t = e.t;
    endtask

    task automatic cycle(input logic r, input logic en, input logic [3:0] lin);
        exp_t e;
        @(negedge sys_clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("led_out", 32'(led_out), 32'(e.led));
            chk("duty", 32'(duty), 32'(e.duty));
            chk("period_tick", 32'(period_tick), 32'(e.tick));
            observe(e);
        end
        reset  = r;
        enable = en;
        led_in = lin;
        edge_n++;
        e.awin = awin;
        if (r) begin
            m_t   = -1;
            rel_n = edge_n;
            e.led = 4'h0; e.duty = 4'h0; e.tick = 1'b0;
        end else if (!en) begin
            m_t   = -1;
            e.led = lin; e.duty = 4'h0; e.tick = 1'b0;
        end else if (m_t < 0) begin
            m_t   = 0;
            e.led = lin; e.duty = 4'h0; e.tick = 1'b0;
        end else begin
            e.led  = lin & {4{model_pwm(m_t) < model_duty(m_t)}};
            m_t++;
            e.duty = 4'(model_duty(m_t));
            e.tick = (m_t % PER) == 0;
        end
        e.t = m_t;
        e.n = edge_n - rel_n;
        sb_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got 0, expected 1 (simulation did not complete)");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        led_in = 4'hF;

        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'hF);

        // Full envelope plus margin, with the duty=5 window and first tick observed
        win5 = 1'b1;
        tarm = 1'b1;
        for (int i = 0; i < ENV + 200; i++) cycle(1'b0, 1'b1, 4'hF);
        win5 = 1'b0;
        tarm = 1'b0;
        chk("first_tick_cycles", 32'(first_tick_n), 32'd65);
        chk("duty5_high_cycles", 32'(hi5), 32'd20);
        chk("duty5_low_cycles", 32'(lo5), 32'd44);

        // Pattern masking during RISE, with a brief pattern change in between
        awin = 1'b1;
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 4'b1010);
        awin = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'hF);
        awin = 1'b1;
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 4'b1010);
        awin = 1'b0;
        cycle(1'b0, 1'b1, 4'hF);
        chk("mask_bit0_high", 32'(a_bit0), 32'd0);
        chk("mask_bit1_high", 32'(a_bit1_obs), 32'(a_bit1_exp));

        // Drop enable in FALL at duty 9, then re-enable
        for (int k = 0; k < 4000 && m_t != ENV + 2866; k++) cycle(1'b0, 1'b1, 4'hF);
        chk("duty_at_drop", 32'(duty), 32'd9);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h6);
        rewin = 1'b1;
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 4'hF);
        rewin = 1'b0;
        chk("restart_first_step_t", 32'(first_d1_t), 32'd129);

        // One-cycle reset pulse in HOLD_HI, then watch the restart
        for (int k = 0; k < 3000 && m_t != 2100; k++) cycle(1'b0, 1'b1, 4'hF);
        chk("duty_at_hold_hi", 32'(duty), 32'd15);
        cycle(1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 4'hC);
        cycle(1'b0, 1'b1, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
